// File: rtl/cdb_rr_arbiter_if.sv
// cdb_rr_arbiter_if: per-FU result handshake plus the registered CDB broadcast.
// master = functional-unit side, slave = the arbiter.
interface cdb_rr_arbiter_if #(parameter int FU_NUM = 3, XLEN = 32, TAG_W = 3);
    logic              flush;
    logic [FU_NUM-1:0] ex_valid;
    logic [XLEN-1:0]   ex_value   [FU_NUM];
    logic [TAG_W-1:0]  ex_rob_tag [FU_NUM];
    logic [31:0]       ex_inst    [FU_NUM];
    logic [XLEN-1:0]   ex_npc     [FU_NUM];
    logic [FU_NUM-1:0] ex_ready;
    logic              cdb_valid;
    logic [XLEN-1:0]   cdb_value;
    logic [TAG_W-1:0]  cdb_rob_tag;
    logic [31:0]       wr_inst;
    logic [XLEN-1:0]   wr_npc;
    logic [FU_NUM-1:0] grant;

    modport master (
        output flush, ex_valid, ex_value, ex_rob_tag, ex_inst, ex_npc,
        input  ex_ready, cdb_valid, cdb_value, cdb_rob_tag, wr_inst, wr_npc, grant
    );
    modport slave (
        input  flush, ex_valid, ex_value, ex_rob_tag, ex_inst, ex_npc,
        output ex_ready, cdb_valid, cdb_value, cdb_rob_tag, wr_inst, wr_npc, grant
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: registered round-robin CDB arbiter with a 1-entry holding buffer per FU.
module cdb_rr_arbiter #(
    parameter int FU_NUM = 3,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 3
) (
    input logic           clk,
    input logic           rst_n,
    cdb_rr_arbiter_if.slave bus
);
    localparam int PTR_W = FU_NUM > 1 ? $clog2(FU_NUM) : 1;

    logic [FU_NUM-1:0]   hold_valid, sel_onehot, ready, accept;
    logic [XLEN-1:0]     hold_value [FU_NUM];
    logic [TAG_W-1:0]    hold_tag   [FU_NUM];
    logic [31:0]         hold_inst  [FU_NUM];
    logic [XLEN-1:0]     hold_npc   [FU_NUM];
    logic [PTR_W-1:0]    rr_ptr, sel, nxt_ptr;
    logic [PTR_W:0]      off, sum;
    logic [2*FU_NUM-1:0] rot;
    logic                found;

    // Rotate so bit 0 is the entry at rr_ptr; the lowest set bit is the winner's offset.
    always_comb begin
        rot = {hold_valid, hold_valid} >> rr_ptr;
        off = '0;
        for (int j = FU_NUM - 1; j >= 0; j--)
            if (rot[j]) off = (PTR_W+1)'(j);
        found      = |hold_valid & ~bus.flush;
        sum        = {1'b0, rr_ptr} + off;
        sel        = sum >= (PTR_W+1)'(FU_NUM) ? PTR_W'(sum - (PTR_W+1)'(FU_NUM)) : PTR_W'(sum);
        sel_onehot = found ? FU_NUM'(1) << sel : '0;
        nxt_ptr    = sel == PTR_W'(FU_NUM - 1) ? '0 : sel + 1'b1;
        ready      = {FU_NUM{~bus.flush}} & (~hold_valid | sel_onehot);
        accept     = bus.ex_valid & ready;
    end

    assign bus.ex_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid      <= '0;
            rr_ptr          <= '0;
            bus.cdb_valid   <= 1'b0;
            bus.cdb_value   <= '0;
            bus.cdb_rob_tag <= '0;
            bus.wr_inst     <= '0;
            bus.wr_npc      <= '0;
            bus.grant       <= '0;
            for (int i = 0; i < FU_NUM; i++) begin
                hold_value[i] <= '0;
                hold_tag[i]   <= '0;
                hold_inst[i]  <= '0;
                hold_npc[i]   <= '0;
            end
        end else begin
            // A refill of the slot being granted keeps it valid with the new packet.
            hold_valid      <= bus.flush ? '0 : accept | (hold_valid & ~sel_onehot);
            rr_ptr          <= bus.flush ? '0 : found ? nxt_ptr : rr_ptr;
            bus.cdb_valid   <= found;
            bus.cdb_value   <= found ? hold_value[sel] : '0;
            bus.cdb_rob_tag <= found ? hold_tag[sel] : '0;
            bus.wr_inst     <= found ? hold_inst[sel] : '0;
            bus.wr_npc      <= found ? hold_npc[sel] : '0;
            bus.grant       <= sel_onehot;
            for (int i = 0; i < FU_NUM; i++) begin
                if (accept[i]) begin
                    hold_value[i] <= bus.ex_value[i];
                    hold_tag[i]   <= bus.ex_rob_tag[i];
                    hold_inst[i]  <= bus.ex_inst[i];
                    hold_npc[i]   <= bus.ex_npc[i];
                end
            end
        end
    end
endmodule
